// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full_adder plus a carry flip-flop, LSB-first over WIDTH cycles.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_sum, fa_cout;
    logic [WIDTH-1:0] psum_shift;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New bit enters at the MSB so the LSB-first result lands aligned after WIDTH shifts.
    always_comb begin
        psum_shift = psum_q >> 1;
        psum_shift[WIDTH-1] = fa_sum;
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    psum_d  = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                psum_d  = psum_shift;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LastBit) begin
                    state_d = StDone;
                    sum_d   = psum_shift;
                    cout_d  = fa_cout;
                    // carry_q is the carry into the MSB on the final bit
                    ovf_d   = carry_q ^ fa_cout;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8; checks handshake timing, results and reset abort.
// Covers ovf as well when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [WIDTH-1:0] prev_sum;

    serial_adder_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; request is accepted at the following posedge (T0).
    task automatic issue(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, input logic ci);
        start = 1'b1;
        a     = ai;
        b     = bi;
        cin   = ci;
        @(negedge clk);
        start = 1'b0;
        a     = '1;
        b     = '1;
        cin   = 1'b1;
    endtask

    // Called at a negedge inside RUN; counts busy cycles and checks the completion cycle.
    task automatic finish_op(input string tag, input int exp_cycles,
                             input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int n = 0;
        while (busy && n < 40) begin
            n++;
            if (sum !== prev_sum) check({tag, "_hold"}, 32'(sum), 32'(prev_sum));
            @(negedge clk);
        end
        check({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected ovf arg");
`endif
        prev_sum = es;
    endtask

    initial begin
        int saw_done;
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_sum", 32'(sum), 32'h0);
        check("rst_cout", 32'(cout), 32'd0);
        prev_sum = '0;

        // zero + zero
        issue(8'h00, 8'h00, 1'b0);
        check("zero_busy", 32'(busy), 32'd1);
        finish_op("zero", 8, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("zero_done_fall", 32'(done), 32'd0);
        check("zero_idle_busy", 32'(busy), 32'd0);

        // full carry ripple
        issue(8'hFF, 8'h01, 1'b0);
        finish_op("ripple", 8, 8'h00, 1'b1, 1'b0);
        @(negedge clk);

        // carry-in propagation, then back-to-back start in the DONE cycle
        issue(8'h5A, 8'hA5, 1'b1);
        finish_op("cin", 8, 8'h00, 1'b1, 1'b0);
        issue(8'h03, 8'h04, 1'b0);
        check("b2b_done_fall", 32'(done), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        finish_op("b2b", 8, 8'h07, 1'b0, 1'b0);
        @(negedge clk);

        // start during busy is ignored
        issue(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        issue(8'hFF, 8'hFF, 1'b0);
        check("ign_busy", 32'(busy), 32'd1);
        finish_op("ign", 5, 8'h30, 1'b0, 1'b0);
        @(negedge clk);
        check("ign_not_queued", 32'(busy), 32'd0);

        // reset aborts an operation in flight
        issue(8'h33, 8'h44, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'h0);
        check("abort_cout", 32'(cout), 32'd0);
        prev_sum = '0;
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) saw_done++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(saw_done), 32'd0);

`ifdef SERIAL_ADDER_OVF_EN
        issue(8'h7F, 8'h01, 1'b0);
        finish_op("ovf_pos", 8, 8'h80, 1'b0, 1'b1);
        @(negedge clk);
        check("ovf_hold", 32'(ovf), 32'd1);
        issue(8'hFF, 8'h01, 1'b0);
        finish_op("ovf_none", 8, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
